// File: rtl/force_arbiter.sv
// force_arbiter: round-robin sequencer sharing one spring-force unit.
// Optional WAIT-state timeout enabled by defining FORCE_ARB_TIMEOUT_EN.
module force_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_dx,
  input  logic [NUM_REQ*DATA_W-1:0] req_dy,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      unit_start,
  output logic [DATA_W-1:0]         unit_dx,
  output logic [DATA_W-1:0]         unit_dy,
  input  logic                      unit_done,
  input  logic [DATA_W-1:0]         unit_result
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     sel;
  logic              found;
  logic [DATA_W-1:0] dx_q, dx_d;
  logic [DATA_W-1:0] dy_q, dy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_REQ-1:0] oh;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 2 || TIMEOUT < 1)
  begin : g_param_chk
    $error("force_arbiter: parameter out of range");
  end

`ifdef FORCE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // first requester at or above the pointer, wrapping around
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // one-hot decode of the granted index
  always_comb begin
    oh = '0;
    oh[idx_q] = 1'b1;
  end

  // next-state and datapath latching
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    data_d  = data_q;
`ifdef FORCE_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = sel;
          dx_d    = req_dx[int'(sel)*DATA_W +: DATA_W];
          dy_d    = req_dy[int'(sel)*DATA_W +: DATA_W];
          state_d = ISSUE;
`ifdef FORCE_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FORCE_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (unit_done) begin
          data_d  = unit_result;
          state_d = RESP;
        end
`ifdef FORCE_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = SMAX;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      data_q  <= '0;
`ifdef FORCE_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      data_q  <= data_d;
`ifdef FORCE_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt        = (state_q != IDLE) ? oh : '0;
  assign rsp_valid  = (state_q == RESP) ? oh : '0;
  assign unit_start = (state_q == ISSUE);
  assign unit_dx    = dx_q;
  assign unit_dy    = dy_q;
  assign rsp_data   = data_q;

`ifdef FORCE_ARB_TIMEOUT_EN
  assign rsp_err = err_q && (state_q == RESP);
`else
  assign rsp_err = 1'b0;
`endif

endmodule
